// File: rtl/simple_cpu_pkg.sv
// Shared types and constants for the Simple_CPU control sequencer.
package simple_cpu_pkg;

    // Instruction opcodes as set on the OpcodeInput switches.
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_MUL  = 4'hA,
        OP_CLR  = 4'hB
    } opcode_t;

    // Sequencer states, one instruction per pass from IDLE back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MUL_IT = 3'd4,
        ST_WRITE  = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_t;

    localparam logic [3:0] OP_ILLEGAL_MIN = 4'hC;

    // Opcodes 0xC..0xF have no defined meaning.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= OP_ILLEGAL_MIN);
    endfunction

endpackage

// File: rtl/simple_cpu_sequencer_debounce.sv
// Synchroniser plus stability counter for the Execute push-button.
// Produces a debounced level and a one-cycle pulse on each armed 0->1 change.
module button_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic Rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   armed_q, armed_d;
    logic                   synced_s;

    assign synced_s = sync_q[SYNC_STAGES-1];
    assign level    = level_q;
    assign rise     = rise_q;

    // Next-state: shift synchroniser, count stable differing samples, flip level.
    // A rise is only reported once a released sample has been seen since reset,
    // so a button held through reset needs a full release/press cycle.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        armed_d = armed_q | ~synced_s;
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        if (synced_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q & armed_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers; synchroniser resets to "pressed" so a held button cannot arm.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sync_q  <= {SYNC_STAGES{1'b1}};
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/simple_cpu_sequencer.sv
// Control FSM sequencing the Simple_CPU datapath, one instruction per Execute press.
// All outputs are registered and derived from the next state, so each strobe is
// visible during the cycle the FSM spends in the corresponding state.
module simple_cpu_sequencer
    import simple_cpu_pkg::*;
#(
    parameter int WIDTH_OPCODE        = 4,
    parameter int WIDTH_SWITCH_LENGTH = 6,
    parameter int DEBOUNCE_CYCLES     = 16
) (
    input  logic                           clk,
    input  logic                           Rst,
    input  logic [WIDTH_OPCODE-1:0]        OpcodeInput,
    input  logic [WIDTH_SWITCH_LENGTH-1:0] ExternalSwitch,
    input  logic                           Execute,
    output logic [WIDTH_OPCODE-1:0]        AluOp,
    output logic [WIDTH_SWITCH_LENGTH-1:0] OperandB,
    output logic                           AccWriteEn,
    output logic                           AccClear,
    output logic                           MulStep,
    output logic [2:0]                     StepIndex,
    output logic                           DisplayUpdate,
    output logic                           Busy,
    output logic                           Illegal
);
    localparam logic [2:0] STEP_LAST = 3'(WIDTH_SWITCH_LENGTH - 1);

    logic       level_s, rise_s, start_s;
    seq_state_t state_q, state_d;
    logic [WIDTH_OPCODE-1:0]        opcode_q, opcode_d;
    logic [WIDTH_SWITCH_LENGTH-1:0] operand_b_q, operand_b_d;
    logic [WIDTH_OPCODE-1:0]        alu_op_q, alu_op_d;
    logic [2:0] step_q, step_d;
    logic acc_write_en_q, acc_write_en_d;
    logic acc_clear_q, acc_clear_d;
    logic mul_step_q, mul_step_d;
    logic display_update_q, display_update_d;
    logic busy_q, busy_d;
    logic illegal_q, illegal_d;

    button_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .Rst   (Rst),
        .raw   (Execute),
        .level (level_s),
        .rise  (rise_s)
    );

    // A start is a debounced rising edge while the level is still high.
    assign start_s = rise_s & level_s;

    assign AluOp         = alu_op_q;
    assign OperandB      = operand_b_q;
    assign AccWriteEn    = acc_write_en_q;
    assign AccClear      = acc_clear_q;
    assign MulStep       = mul_step_q;
    assign StepIndex     = step_q;
    assign DisplayUpdate = display_update_q;
    assign Busy          = busy_q;
    assign Illegal       = illegal_q;

    // Next state, latched operands, step counter and the output values for that state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if ((opcode_q == OP_NOP) || is_illegal(opcode_q)) begin
                    state_d = ST_DONE;
                end else if (opcode_q == OP_CLR) begin
                    state_d = ST_WRITE;
                end else if (opcode_q == OP_MUL) begin
                    state_d = ST_MUL_IT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:   state_d = ST_WRITE;
            ST_MUL_IT: begin
                if (step_q == STEP_LAST) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_MUL_IT;
                end
            end
            ST_WRITE:  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Operands are captured on the way into LATCH and held until the next one.
        if (state_d == ST_LATCH) begin
            opcode_d    = OpcodeInput;
            operand_b_d = ExternalSwitch;
        end else begin
            opcode_d    = opcode_q;
            operand_b_d = operand_b_q;
        end

        // Step index restarts only when a MUL is decoded and saturates at the last bit.
        if ((state_d == ST_DECODE) && (opcode_q == OP_MUL)) begin
            step_d = 3'd0;
        end else if ((state_q == ST_MUL_IT) && (state_d == ST_MUL_IT)) begin
            step_d = step_q + 3'd1;
        end else begin
            step_d = step_q;
        end

        if (state_d == ST_LATCH) begin
            illegal_d = 1'b0;
        end else if ((state_d == ST_DECODE) && is_illegal(opcode_q)) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end

        busy_d           = (state_d != ST_IDLE);
        acc_write_en_d   = (state_d == ST_EXEC) || (state_d == ST_MUL_IT);
        mul_step_d       = (state_d == ST_MUL_IT);
        display_update_d = (state_d == ST_WRITE);
        acc_clear_d      = (state_d == ST_DECODE) &&
                           ((opcode_q == OP_CLR) || (opcode_q == OP_MUL));

        if (state_d == ST_MUL_IT) begin
            alu_op_d = OP_MUL;
        end else if (state_d == ST_EXEC) begin
            alu_op_d = opcode_q;
        end else begin
            alu_op_d = '0;
        end
    end

    // FSM state and registered outputs; reset drops every strobe immediately.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q          <= ST_IDLE;
            opcode_q         <= '0;
            operand_b_q      <= '0;
            alu_op_q         <= '0;
            step_q           <= 3'd0;
            acc_write_en_q   <= 1'b0;
            acc_clear_q      <= 1'b0;
            mul_step_q       <= 1'b0;
            display_update_q <= 1'b0;
            busy_q           <= 1'b0;
            illegal_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            opcode_q         <= opcode_d;
            operand_b_q      <= operand_b_d;
            alu_op_q         <= alu_op_d;
            step_q           <= step_d;
            acc_write_en_q   <= acc_write_en_d;
            acc_clear_q      <= acc_clear_d;
            mul_step_q       <= mul_step_d;
            display_update_q <= display_update_d;
            busy_q           <= busy_d;
            illegal_q        <= illegal_d;
        end
    end

endmodule

// File: tb/tb_simple_cpu_sequencer.sv
// Bench for simple_cpu_sequencer: a per-instruction timeline model checked every cycle,
// directed boundary scenarios pinned with literal expectations, then random presses.
module tb_simple_cpu_sequencer;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] op;
    logic [5:0] sw;
    logic       exe;
    logic [3:0] AluOp;
    logic [5:0] OperandB;
    logic       AccWriteEn, AccClear, MulStep, DisplayUpdate, Busy, Illegal;
    logic [2:0] StepIndex;

    always #5 clk = ~clk;

    simple_cpu_sequencer #(
        .WIDTH_OPCODE(4), .WIDTH_SWITCH_LENGTH(6), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .Rst(rst), .OpcodeInput(op), .ExternalSwitch(sw), .Execute(exe),
        .AluOp(AluOp), .OperandB(OperandB), .AccWriteEn(AccWriteEn), .AccClear(AccClear),
        .MulStep(MulStep), .StepIndex(StepIndex), .DisplayUpdate(DisplayUpdate),
        .Busy(Busy), .Illegal(Illegal)
    );

    typedef struct packed {
        logic       busy, wr, clr, mstep, disp, ill;
        logic [3:0] alu;
        logic [5:0] opb;
        logic [2:0] step;
    } exp_t;

    exp_t cur;
    exp_t tl[$];
    logic m_s1, m_s2, m_lvl, m_armed, m_rise;
    int   m_cnt;

    int tests = 0, fails = 0, cyc = 0;
    int n_wr = 0, n_disp = 0, n_mstep = 0, n_busy = 0, n_clr = 0, step_sum = 0;
    int last_alu = 0, wr_cyc = 0, disp_cyc = 0;

    // Expected outputs for every cycle of one instruction, from LATCH to DONE.
    task automatic push_timeline(input logic [3:0] o, input logic [5:0] s);
        exp_t e;
        e = cur;
        e.wr = 1'b0; e.clr = 1'b0; e.mstep = 1'b0; e.disp = 1'b0; e.alu = 4'd0;
        e.busy = 1'b1; e.opb = s; e.ill = 1'b0;
        tl.push_back(e);
        e.ill = (o >= 4'hC);
        e.clr = (o == 4'hA) || (o == 4'hB);
        if (o == 4'hA) e.step = 3'd0;
        tl.push_back(e);
        e.clr = 1'b0;
        if (o == 4'hA) begin
            for (int i = 0; i < 6; i++) begin
                e.wr = 1'b1; e.mstep = 1'b1; e.alu = 4'hA; e.step = 3'(i);
                tl.push_back(e);
            end
            e.wr = 1'b0; e.mstep = 1'b0; e.alu = 4'd0;
            e.disp = 1'b1; tl.push_back(e); e.disp = 1'b0;
        end else if (o == 4'hB) begin
            e.disp = 1'b1; tl.push_back(e); e.disp = 1'b0;
        end else if ((o != 4'h0) && (o < 4'hC)) begin
            e.wr = 1'b1; e.alu = o; tl.push_back(e);
            e.wr = 1'b0; e.alu = 4'd0;
            e.disp = 1'b1; tl.push_back(e); e.disp = 1'b0;
        end
        tl.push_back(e);
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        logic nr, na;
        if (rst) begin
            tl.delete();
            cur = '0;
            m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0; m_cnt = 0; m_armed = 1'b0; m_rise = 1'b0;
            return;
        end
        if (m_rise && !cur.busy) push_timeline(op, sw);
        if (tl.size() > 0) begin
            cur = tl.pop_front();
        end else begin
            cur.busy = 1'b0; cur.wr = 1'b0; cur.clr = 1'b0; cur.mstep = 1'b0;
            cur.disp = 1'b0; cur.alu = 4'd0;
        end
        nr = 1'b0;
        na = m_armed | ~m_s2;
        if (m_s2 != m_lvl) begin
            if (m_cnt == DEB - 1) begin
                nr = ~m_lvl & m_armed;
                m_lvl = ~m_lvl;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end
        m_s2 = m_s1; m_s1 = exe; m_armed = na; m_rise = nr;
    endtask

    task automatic compare_outputs();
        exp_t e, a;
        e = rst ? exp_t'(0) : cur;
        a.busy = Busy; a.wr = AccWriteEn; a.clr = AccClear; a.mstep = MulStep;
        a.disp = DisplayUpdate; a.ill = Illegal; a.alu = AluOp; a.opb = OperandB;
        a.step = StepIndex;
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL outputs t=%0t {busy,wr,clr,mstep,disp,ill,alu,opb,step} got %b required %b",
                     $time, a, e);
        end
        cyc++;
        if (!rst) begin
            n_busy  += int'(Busy);
            n_clr   += int'(AccClear);
            n_mstep += int'(MulStep);
            if (MulStep) step_sum += int'(StepIndex);
            if (AccWriteEn) begin n_wr++; last_alu = int'(AluOp); wr_cyc = cyc; end
            if (DisplayUpdate) begin n_disp++; disp_cyc = cyc; end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic press(input int bounces, input int hold);
        for (int b = 0; b < bounces; b++) begin
            exe = 1'b1; tick();
            exe = 1'b0; tick();
        end
        exe = 1'b1;
        repeat (hold) tick();
        exe = 1'b0;
    endtask

    task automatic rtick();
        if ($urandom_range(3, 0) == 0) op = 4'($urandom_range(15, 0));
        if ($urandom_range(3, 0) == 0) sw = 6'($urandom_range(63, 0));
        tick();
    endtask

    initial begin
        int d_disp, d_wr, d_mstep, d_busy, d_clr, d_sum, found;
        int nb, hold, rel, rpos;
        rst = 1'b1; op = 4'd0; sw = 6'd0; exe = 1'b0;
        cur = '0;
        repeat (3) tick();
        chk("reset_busy", int'(Busy), 0);
        chk("reset_opb", int'(OperandB), 0);
        rst = 1'b0;
        repeat (6) tick();

        // ADD with a bouncing press.
        op = 4'd2; sw = 6'd5;
        d_disp = n_disp; d_wr = n_wr;
        press(2, 6);
        repeat (20) tick();
        chk("add_writes", n_wr - d_wr, 1);
        chk("add_aluop", last_alu, 2);
        chk("add_opb", int'(OperandB), 5);
        chk("add_disp", n_disp - d_disp, 1);
        chk("add_disp_after_write", disp_cyc - wr_cyc, 1);

        // MUL full run.
        op = 4'hA; sw = 6'b101101;
        d_disp = n_disp; d_mstep = n_mstep; d_busy = n_busy; d_clr = n_clr; d_sum = step_sum;
        press(0, 6);
        repeat (25) tick();
        chk("mul_steps", n_mstep - d_mstep, 6);
        chk("mul_step_sum", step_sum - d_sum, 15);
        chk("mul_clear", n_clr - d_clr, 1);
        chk("mul_disp", n_disp - d_disp, 1);
        chk("mul_busy_cycles", n_busy - d_busy, 10);
        chk("mul_step_hold", int'(StepIndex), 5);

        // Illegal opcode, then LOAD clears the flag.
        op = 4'hE; sw = 6'd3;
        d_disp = n_disp; d_wr = n_wr; d_busy = n_busy;
        press(1, 6);
        repeat (20) tick();
        chk("ill_flag", int'(Illegal), 1);
        chk("ill_writes", n_wr - d_wr, 0);
        chk("ill_disp", n_disp - d_disp, 0);
        chk("ill_busy_cycles", n_busy - d_busy, 3);
        op = 4'd1; sw = 6'd7;
        press(0, 6);
        repeat (20) tick();
        chk("load_ill_clear", int'(Illegal), 0);
        chk("load_aluop", last_alu, 1);
        chk("load_opb", int'(OperandB), 7);

        // Re-press during a MUL (lands in DONE), then hold 50 cycles.
        op = 4'hA; sw = 6'd9;
        d_disp = n_disp;
        press(0, 6);
        repeat (4) tick();
        exe = 1'b1;
        repeat (50) tick();
        exe = 1'b0;
        repeat (20) tick();
        chk("repress_one_instr", n_disp - d_disp, 1);

        // Opcode switched to AND while SUB is in flight.
        op = 4'd3; sw = 6'd12;
        press(0, 6);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (Busy) found = 1;
        end
        chk("sub_started", found, 1);
        tick();
        op = 4'd4; sw = 6'd33;
        repeat (15) tick();
        chk("sub_aluop", last_alu, 3);
        chk("sub_opb", int'(OperandB), 12);

        // Reset in the middle of a MUL.
        op = 4'hA; sw = 6'b110011;
        d_disp = n_disp;
        press(0, 6);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            tick();
            if (MulStep && StepIndex == 3'd3) found = 1;
        end
        chk("mul_reach_step3", found, 1);
        rst = 1'b1;
        #1;
        chk("rst_busy", int'(Busy), 0);
        chk("rst_mulstep", int'(MulStep), 0);
        chk("rst_step", int'(StepIndex), 0);
        tick(); tick();
        rst = 1'b0;
        repeat (15) tick();
        chk("rst_no_disp", n_disp - d_disp, 0);

        // Button held through reset release.
        op = 4'd2; sw = 6'd1;
        d_busy = n_busy;
        exe = 1'b1; rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("held_rst_no_start", n_busy - d_busy, 0);
        exe = 1'b0;
        repeat (10) tick();
        d_disp = n_disp;
        press(0, 6);
        repeat (15) tick();
        chk("held_rst_then_press", n_disp - d_disp, 1);

        // Random presses, bounces, operand churn and occasional resets.
        for (int it = 0; it < 40; it++) begin
            op = 4'($urandom_range(15, 0));
            sw = 6'($urandom_range(63, 0));
            nb = int'($urandom_range(3, 0));
            hold = int'($urandom_range(20, 4));
            rel = int'($urandom_range(14, 1));
            rpos = ($urandom_range(11, 0) == 0) ? int'($urandom_range(20, 0)) : -1;
            for (int b = 0; b < nb; b++) begin
                exe = 1'b1; rtick();
                exe = 1'b0; rtick();
            end
            exe = 1'b1;
            for (int h = 0; h < hold; h++) begin
                rst = (h == rpos);
                rtick();
            end
            rst = 1'b0;
            exe = 1'b0;
            for (int r = 0; r < rel; r++) rtick();
        end
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
